prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Writer side of the CPU's 32x8 instruction/data memory.
- Accepts a framed byte stream over a valid/ready interface and writes the payload into memory through the memory's write port.
- Verifies an XOR checksum, then releases the CPU from hold.
- Sits beside cpu; the integration muxes its address, data and write strobe onto the memory port while cpu_hold is high.

Parameters:
- ADDR_WIDTH, 5, memory address width; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 8, memory word and stream byte width.
- BASE_ADDR, 0, first memory address written; the write pointer wraps modulo depth.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begins a load session; honoured only in IDLE, DONE or ERROR.
- in_valid  in  1  stream byte valid.
- in_data  in  DATA_WIDTH  stream byte.
- in_ready  out  1  loader accepts a byte; transfer occurs when in_valid and in_ready are both high on a clock edge.
- mem_addr  out  ADDR_WIDTH  memory write address.
- mem_data  out  DATA_WIDTH  memory write data; 0 when mem_wr is low.
- mem_wr  out  1  one-cycle write strobe; memory samples on the same edge.
- cpu_hold  out  1  high keeps the CPU in reset and gives the memory port to the loader.
- done  out  1  sticky; set when a load succeeds.
- err  out  1  sticky; set when a load fails.

Behaviour:
- Reset, asynchronous and active-low:
  - State = IDLE.
  - in_ready = 0, mem_wr = 0, mem_addr = BASE_ADDR, mem_data = 0.
  - cpu_hold = 1, done = 0, err = 0.
  - Internal count, pointer and checksum are cleared.
- Frame format, in order:
  - COUNT byte N, valid range 1..depth.
  - N payload bytes.
  - One checksum byte, equal to the XOR of the N payload bytes.
- IDLE / DONE / ERROR:
  - in_ready = 0.
  - On start = 1, go to COUNT.
  - On that transition: clear done and err, set cpu_hold = 1, pointer = BASE_ADDR, checksum = 0.
- COUNT:
  - in_ready = 1.
  - On handshake, if in_data is 0 or greater than depth: go to ERROR and set err.
  - Otherwise latch remaining = N and go to DATA.
- DATA:
  - in_ready = 1.
  - On handshake: latch the byte, checksum ^= byte, go to WRITE.
- WRITE:
  - in_ready = 0.
  - For exactly one cycle: mem_wr = 1, mem_addr = pointer, mem_data = latched byte.
  - Then pointer increments (wrapping at depth) and remaining decrements.
  - If remaining reaches 0, go to CSUM; otherwise go to DATA.
  - Peak throughput is one payload byte per 2 cycles.
- CSUM:
  - in_ready = 1.
  - On handshake, if in_data equals checksum: go to DONE, set done = 1, cpu_hold = 0.
  - Otherwise go to ERROR, set err = 1, cpu_hold stays 1.
- Outputs are registered; in_ready and mem_wr change only on clock edges.
- A start asserted in COUNT, DATA, WRITE or CSUM is ignored.
- in_valid low in any accepting state: the FSM waits indefinitely with no timeout.
- Wrap-around: with BASE_ADDR = 30 and N = 4, writes go to addresses 30, 31, 0, 1.
- Reset mid-load:
  - Returns immediately to reset values.
  - Memory already written is not restored.
  - cpu_hold stays 1 until a later load succeeds.
- done and err are never both 1.
- cpu_hold returns to 1 only on reset or on an accepted start.

Test Plan:
- Reset, then start; stream 03, A1, B2, C3, D0 (D0 = A1^B2^C3) -> mem_wr pulses at addresses 0, 1, 2 with data A1, B2, C3; done = 1, err = 0, cpu_hold = 0; no mem_wr during COUNT or CSUM.
- Same frame with checksum FF -> all three writes occur, err = 1, done = 0, cpu_hold = 1.
- COUNT byte 00, then a separate run with COUNT byte 21 -> ERROR after the COUNT handshake, no mem_wr, err = 1.
- BASE_ADDR = 30, frame 04, 11, 22, 33, 44, 44 -> writes to addresses 30, 31, 0, 1; done = 1.
- in_valid toggled randomly during a 32-byte load, with start pulsed mid-load -> start is ignored, all 32 addresses written in order, in_ready low in every WRITE cycle.
- rst driven low during DATA, then released, then a fresh valid frame -> outputs at reset values while rst is low; the second load completes with done = 1.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: writes a framed, checksummed byte stream into
// instruction memory and releases the CPU once the load verifies.
module prog_loader #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_wr,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        DATA,
        WRITE,
        CSUM,
        DONE,
        ERROR
    } state_t;

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

    state_t state;
    state_t state_nx;

    logic [DATA_WIDTH-1:0] remaining;
    logic [DATA_WIDTH-1:0] csum;
    logic                  xfer;
    logic                  count_bad;
    logic                  csum_ok;

    assign xfer      = in_valid & in_ready;
    assign count_bad = (in_data == '0) || (32'(in_data) > DEPTH);
    assign csum_ok   = (in_data == csum);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode; WRITE always lasts a single cycle.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE, DONE, ERROR: begin
                if (start) state_nx = COUNT;
            end
            COUNT: begin
                if (xfer) state_nx = count_bad ? ERROR : DATA;
            end
            DATA: begin
                if (xfer) state_nx = WRITE;
            end
            WRITE: begin
                state_nx = (remaining == DATA_WIDTH'(1)) ? CSUM : DATA;
            end
            CSUM: begin
                if (xfer) state_nx = csum_ok ? DONE : ERROR;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Registered outputs and datapath, driven from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ready  <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= BASE;
            mem_data  <= '0;
            cpu_hold  <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            remaining <= '0;
            csum      <= '0;
        end else begin
            in_ready <= state_nx inside {COUNT, DATA, CSUM};
            mem_wr   <= (state_nx == WRITE);
            mem_data <= '0;
            unique case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        done     <= 1'b0;
                        err      <= 1'b0;
                        cpu_hold <= 1'b1;
                        mem_addr <= BASE;
                        csum     <= '0;
                    end
                end
                COUNT: begin
                    if (xfer) begin
                        if (count_bad) err <= 1'b1;
                        else remaining <= in_data;
                    end
                end
                DATA: begin
                    if (xfer) begin
                        csum     <= csum ^ in_data;
                        mem_data <= in_data;
                    end
                end
                WRITE: begin
                    mem_addr  <= mem_addr + 1'b1;
                    remaining <= remaining - 1'b1;
                end
                CSUM: begin
                    if (xfer) begin
                        if (csum_ok) begin
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed frame vectors against two loader
// instances (base address 0 and base address 30).
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start0 = 1'b0;
    logic       start1 = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;

    logic       rdy0, wr0, hold0, done0, err0;
    logic [4:0] addr0;
    logic [7:0] data0;
    logic       rdy1, wr1, hold1, done1, err1;
    logic [4:0] addr1;
    logic [7:0] data1;

    int total = 0;
    int bad = 0;
    int rdy_viol = 0;
    int dz_viol = 0;

    logic [15:0] log0[$];
    logic [15:0] log1[$];

    always #5 clk = ~clk;

    prog_loader #(.ADDR_WIDTH(5), .DATA_WIDTH(8), .BASE_ADDR(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0),
        .in_valid(in_valid), .in_data(in_data), .in_ready(rdy0),
        .mem_addr(addr0), .mem_data(data0), .mem_wr(wr0),
        .cpu_hold(hold0), .done(done0), .err(err0)
    );

    prog_loader #(.ADDR_WIDTH(5), .DATA_WIDTH(8), .BASE_ADDR(30)) dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .in_valid(in_valid), .in_data(in_data), .in_ready(rdy1),
        .mem_addr(addr1), .mem_data(data1), .mem_wr(wr1),
        .cpu_hold(hold1), .done(done1), .err(err1)
    );

    // Write monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (wr0) begin
            log0.push_back({3'b0, addr0, data0});
            if (rdy0) rdy_viol++;
        end else if (data0 != 8'h00) begin
            dz_viol++;
        end
        if (wr1) begin
            log1.push_back({3'b0, addr1, data1});
            if (rdy1) rdy_viol++;
        end else if (data1 != 8'h00) begin
            dz_viol++;
        end
    end

    typedef struct {
        logic        sel;
        int          n;
        logic [63:0] b;
        logic        exp_done;
        logic        exp_err;
        int          exp_wr;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic pulse_start(input logic sel);
        if (sel) start1 = 1'b1;
        else start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic send(input logic sel, input logic [7:0] b,
                        input int gap);
        int  g;
        bit  ok;
        g = (gap > 0) ? int'($urandom_range(0, gap)) : 0;
        repeat (g) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            if ((sel ? rdy1 : rdy0) === 1'b1) ok = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_data  = 8'h00;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout got=%0h want=accepted", b);
        end
    endtask

    task automatic check_status(input string tag, input logic sel,
                                input logic ed, input logic ee);
        chk({tag, "_done"}, sel ? done1 : done0, ed);
        chk({tag, "_err"}, sel ? err1 : err0, ee);
        chk({tag, "_hold"}, sel ? hold1 : hold0, !ed);
    endtask

    task automatic check_writes(input string tag, input logic sel,
                                input logic [7:0] p[$]);
        logic [15:0] q[$];
        logic [4:0]  a;
        q = sel ? log1 : log0;
        chk({tag, "_nwr"}, q.size(), p.size());
        for (int i = 0; i < p.size() && i < q.size(); i++) begin
            a = sel ? 5'(30 + i) : 5'(i);
            chk({tag, "_wr"}, q[i], {3'b0, a, p[i]});
        end
    endtask

    task automatic run_vec(input int idx);
        vec_t        v;
        logic [7:0]  p[$];
        logic [7:0]  bb;
        v = vecs[idx];
        log0.delete();
        log1.delete();
        pulse_start(v.sel);
        for (int i = 0; i < v.n; i++) begin
            bb = v.b[63-8*i -: 8];
            send(v.sel, bb, 0);
            if (i >= 1 && i <= v.exp_wr) p.push_back(bb);
        end
        repeat (3) @(negedge clk);
        check_status($sformatf("vec%0d", idx), v.sel, v.exp_done,
                     v.exp_err);
        check_writes($sformatf("vec%0d", idx), v.sel, p);
    endtask

    initial begin
        logic [7:0] p[$];
        logic [7:0] x;

        vecs[0] = '{1'b0, 5, 64'h03A1B2C3D0000000, 1'b1, 1'b0, 3};
        vecs[1] = '{1'b0, 5, 64'h03A1B2C3FF000000, 1'b0, 1'b1, 3};
        vecs[2] = '{1'b0, 1, 64'h0000000000000000, 1'b0, 1'b1, 0};
        vecs[3] = '{1'b0, 1, 64'h2100000000000000, 1'b0, 1'b1, 0};
        vecs[4] = '{1'b1, 6, 64'h0411223344440000, 1'b1, 1'b0, 4};

        repeat (2) @(negedge clk);
        chk("rst_rdy0", rdy0, 1'b0);
        chk("rst_wr0", wr0, 1'b0);
        chk("rst_addr0", addr0, 5'd0);
        chk("rst_data0", data0, 8'h00);
        chk("rst_hold0", hold0, 1'b1);
        chk("rst_done0", done0, 1'b0);
        chk("rst_err0", err0, 1'b0);
        chk("rst_addr1", addr1, 5'd30);
        chk("rst_hold1", hold1, 1'b1);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) run_vec(i);

        // 32-byte load with random gaps and an ignored start pulse.
        log0.delete();
        pulse_start(1'b0);
        send(1'b0, 8'h20, 3);
        x = 8'h00;
        for (int i = 0; i < 32; i++) begin
            p.push_back(8'(i * 7 + 3));
            x ^= 8'(i * 7 + 3);
            if (i == 10) pulse_start(1'b0);
            send(1'b0, 8'(i * 7 + 3), 3);
        end
        send(1'b0, x, 3);
        repeat (3) @(negedge clk);
        check_status("long", 1'b0, 1'b1, 1'b0);
        check_writes("long", 1'b0, p);

        // Reset in the middle of a load, then a fresh frame.
        pulse_start(1'b0);
        send(1'b0, 8'h03, 0);
        send(1'b0, 8'hA1, 0);
        rst = 1'b0;
        #1;
        chk("mid_rdy", rdy0, 1'b0);
        chk("mid_wr", wr0, 1'b0);
        chk("mid_addr", addr0, 5'd0);
        chk("mid_data", data0, 8'h00);
        chk("mid_hold", hold0, 1'b1);
        chk("mid_done", done0, 1'b0);
        chk("mid_err", err0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        log0.delete();
        p.delete();
        pulse_start(1'b0);
        send(1'b0, 8'h02, 0);
        send(1'b0, 8'h5A, 0);
        send(1'b0, 8'hA5, 0);
        send(1'b0, 8'hFF, 0);
        repeat (3) @(negedge clk);
        p.push_back(8'h5A);
        p.push_back(8'hA5);
        check_status("after_rst", 1'b0, 1'b1, 1'b0);
        check_writes("after_rst", 1'b0, p);

        chk("ready_in_write", rdy_viol, 0);
        chk("data_zero_idle", dz_viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
